// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one single-port 64-bit SRAM between the instruction-fetch port
//   (128-bit lines fetched as two consecutive words) and the load/store port
//   (single-word reads, byte-masked writes). Round-robin arbitration, one
//   outstanding transaction, responses held until accepted.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   ifu_valid/ready     fetch request handshake, ifu_addr word address (bit 0 ignored)
//   ifu_rsp_valid/ready fetch response handshake, ifu_rdata = {word[odd], word[even]}
//   lsu_valid/ready     load/store request handshake with addr/wen/wdata/wstrb
//   lsu_rsp_valid/ready load/store response handshake, lsu_rdata (0 for write ack)
//   sram_*              SRAM access port; sram_rdata valid the cycle after a read
module sram_arbiter #(
   parameter int unsigned AW = 14
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          ifu_valid,
   output logic          ifu_ready,
   input  logic [AW-1:0] ifu_addr,
   output logic          ifu_rsp_valid,
   input  logic          ifu_rsp_ready,
   output logic [127:0]  ifu_rdata,
   input  logic          lsu_valid,
   output logic          lsu_ready,
   input  logic [AW-1:0] lsu_addr,
   input  logic          lsu_wen,
   input  logic [63:0]   lsu_wdata,
   input  logic [7:0]    lsu_wstrb,
   output logic          lsu_rsp_valid,
   input  logic          lsu_rsp_ready,
   output logic [63:0]   lsu_rdata,
   output logic          sram_en,
   output logic          sram_wen,
   output logic [AW-1:0] sram_addr,
   output logic [63:0]   sram_wdata,
   output logic [7:0]    sram_wstrb,
   input  logic [63:0]   sram_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      IF_HI,
      IF_CAP,
      LS_CAP,
      RSP_IF,
      RSP_LS
   } state_t;

   state_t        state;
   logic          last_ls;   // 1 = load/store port was granted last
   logic          gap;       // forces one idle cycle after each response handshake
   logic [AW-1:0] if_base;   // even word address of the line being fetched
   logic          ls_wen;
   logic          grant_if;
   logic          grant_ls;
   logic [AW-1:0] fetch_base;

   assign fetch_base = ifu_addr & ~AW'(1);

   always_comb begin
      grant_if = 1'b0;
      grant_ls = 1'b0;
      if (state == IDLE && !gap && !RST) begin
         if (ifu_valid && (!lsu_valid || last_ls))
            grant_if = 1'b1;
         else if (lsu_valid)
            grant_ls = 1'b1;
      end
   end

   always_comb begin
      ifu_ready     = grant_if;
      lsu_ready     = grant_ls;
      ifu_rsp_valid = (state == RSP_IF);
      lsu_rsp_valid = (state == RSP_LS);
      sram_en       = 1'b0;
      sram_wen      = 1'b0;
      sram_addr     = '0;
      sram_wdata    = '0;
      sram_wstrb    = '0;
      if (grant_if) begin
         sram_en   = 1'b1;
         sram_addr = fetch_base;
      end else if (grant_ls) begin
         sram_en    = 1'b1;
         sram_wen   = lsu_wen;
         sram_addr  = lsu_addr;
         sram_wdata = lsu_wdata;
         sram_wstrb = lsu_wstrb;
      end else if (state == IF_HI) begin
         // second beat stays inside the line: no carry out of bit 0
         sram_en   = 1'b1;
         sram_addr = if_base | AW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         last_ls   <= 1'b1;
         gap       <= 1'b0;
         if_base   <= '0;
         ls_wen    <= 1'b0;
         ifu_rdata <= '0;
         lsu_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               gap <= 1'b0;
               if (grant_if) begin
                  last_ls <= 1'b0;
                  if_base <= fetch_base;
                  state   <= IF_HI;
               end else if (grant_ls) begin
                  last_ls <= 1'b1;
                  ls_wen  <= lsu_wen;
                  state   <= LS_CAP;
               end
            end
            IF_HI: begin
               ifu_rdata[63:0] <= sram_rdata;
               state           <= IF_CAP;
            end
            IF_CAP: begin
               ifu_rdata[127:64] <= sram_rdata;
               state             <= RSP_IF;
            end
            LS_CAP: begin
               lsu_rdata <= ls_wen ? '0 : sram_rdata;
               state     <= RSP_LS;
            end
            RSP_IF: begin
               if (ifu_rsp_ready) begin
                  gap   <= 1'b1;
                  state <= IDLE;
               end
            end
            RSP_LS: begin
               if (lsu_rsp_ready) begin
                  gap   <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Directed bench for sram_arbiter with an SRAM model, a timestamp-based
//   reference model checked every cycle, and literal expectations per scenario.
module tb_sram_arbiter;

   localparam int AW = 14;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          ifu_valid = 1'b0;
   logic          ifu_ready;
   logic [AW-1:0] ifu_addr = '0;
   logic          ifu_rsp_valid;
   logic          ifu_rsp_ready = 1'b1;
   logic [127:0]  ifu_rdata;
   logic          lsu_valid = 1'b0;
   logic          lsu_ready;
   logic [AW-1:0] lsu_addr = '0;
   logic          lsu_wen = 1'b0;
   logic [63:0]   lsu_wdata = '0;
   logic [7:0]    lsu_wstrb = '0;
   logic          lsu_rsp_valid;
   logic          lsu_rsp_ready = 1'b1;
   logic [63:0]   lsu_rdata;
   logic          sram_en;
   logic          sram_wen;
   logic [AW-1:0] sram_addr;
   logic [63:0]   sram_wdata;
   logic [7:0]    sram_wstrb;
   logic [63:0]   sram_rdata = '0;

   sram_arbiter #(.AW(AW)) dut (
      .CLK(CLK), .RST(RST),
      .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_addr(ifu_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
      .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb), .sram_rdata(sram_rdata)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d,
                                         input logic [7:0] s);
      logic [63:0] r;
      r = o;
      for (int b = 0; b < 8; b++)
         if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   // SRAM device model
   logic [63:0] mem [0:(1<<AW)-1];
   always @(posedge CLK) begin
      if (sram_en) begin
         if (sram_wen) begin
            for (int b = 0; b < 8; b++)
               if (sram_wstrb[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   // Reference model: transaction timestamps, not DUT states
   logic [63:0]   refmem [0:(1<<AW)-1];
   bit            chk_on   = 1'b0;
   int            m_kind   = 0;     // 0 none, 1 fetch outstanding, 2 load/store outstanding
   bit            m_last_ls = 1'b1;
   int            m_free_at = 0;
   int            m_beat2   = -1;
   int            m_rsp_from = 0;
   logic [AW-1:0] m_b2addr = '0;
   logic [127:0]  m_data   = '0;
   bit            prev_rst = 1'b0;
   logic          e_ifr, e_lsr, e_en, e_wen, e_ifv, e_lsv;
   logic [AW-1:0] e_addr, base;
   logic [63:0]   e_wd;
   logic [7:0]    e_ws;

   always @(negedge CLK) begin
      if (chk_on) begin
         e_ifr = 0; e_lsr = 0; e_en = 0; e_wen = 0;
         e_addr = '0; e_wd = '0; e_ws = '0;
         base = {ifu_addr[AW-1:1], 1'b0};
         if (m_kind == 1 && cyc == m_beat2) begin
            e_en = 1; e_addr = m_b2addr;
         end
         e_ifv = (m_kind == 1) && (cyc >= m_rsp_from);
         e_lsv = (m_kind == 2) && (cyc >= m_rsp_from);
         if (!RST && m_kind == 0 && cyc >= m_free_at) begin
            if (ifu_valid && (!lsu_valid || m_last_ls)) e_ifr = 1;
            else if (lsu_valid) e_lsr = 1;
         end
         if (e_ifr) begin
            e_en = 1; e_addr = base;
         end
         if (e_lsr) begin
            e_en = 1; e_wen = lsu_wen; e_addr = lsu_addr; e_wd = lsu_wdata; e_ws = lsu_wstrb;
         end
         chk("m_ifu_ready", 128'(ifu_ready), 128'(e_ifr));
         chk("m_lsu_ready", 128'(lsu_ready), 128'(e_lsr));
         chk("m_sram_en", 128'(sram_en), 128'(e_en));
         chk("m_sram_wen", 128'(sram_wen), 128'(e_wen));
         chk("m_sram_wdata", 128'(sram_wdata), 128'(e_wd));
         chk("m_sram_wstrb", 128'(sram_wstrb), 128'(e_ws));
         if (e_en) chk("m_sram_addr", 128'(sram_addr), 128'(e_addr));
         chk("m_ifu_rsp_valid", 128'(ifu_rsp_valid), 128'(e_ifv));
         chk("m_lsu_rsp_valid", 128'(lsu_rsp_valid), 128'(e_lsv));
         if (e_ifv) chk("m_ifu_rdata", ifu_rdata, m_data);
         if (e_lsv) chk("m_lsu_rdata", 128'(lsu_rdata), 128'(m_data[63:0]));
         if (prev_rst) begin
            chk("m_rst_ifu_rdata", ifu_rdata, '0);
            chk("m_rst_lsu_rdata", 128'(lsu_rdata), '0);
         end
         if ((e_ifv && ifu_rsp_ready) || (e_lsv && lsu_rsp_ready)) begin
            m_kind = 0; m_free_at = cyc + 2;
         end
         if (e_ifr) begin
            m_kind = 1; m_beat2 = cyc + 1; m_b2addr = base + AW'(1);
            m_rsp_from = cyc + 3; m_data = {refmem[base + AW'(1)], refmem[base]};
            m_last_ls = 0;
         end
         if (e_lsr) begin
            m_kind = 2; m_rsp_from = cyc + 2; m_last_ls = 1;
            m_data = lsu_wen ? '0 : 128'(refmem[lsu_addr]);
            if (lsu_wen) refmem[lsu_addr] = merge(refmem[lsu_addr], lsu_wdata, lsu_wstrb);
         end
         prev_rst = RST;
         if (RST) begin
            m_kind = 0; m_last_ls = 1; m_free_at = cyc + 1;
         end
      end
   end

   task automatic do_lsu(input logic w, input logic [AW-1:0] a, input logic [63:0] wd,
                         input logic [7:0] ws, output int g, output int r, output logic [63:0] d);
      bit ok1, ok2;
      lsu_wen = w; lsu_addr = a; lsu_wdata = wd; lsu_wstrb = ws; lsu_valid = 1;
      ok1 = 0; ok2 = 0; g = -1; r = -1; d = '0;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (lsu_ready) begin ok1 = 1; g = cyc; break; end
      end
      @(posedge CLK); #1;
      lsu_valid = 0; lsu_wen = 0; lsu_wdata = '0; lsu_wstrb = '0;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (lsu_rsp_valid) begin ok2 = 1; r = cyc; d = lsu_rdata; break; end
      end
      @(posedge CLK); #1;
      chk("lsu_grant_seen", 128'(ok1), 128'(1));
      chk("lsu_rsp_seen", 128'(ok2), 128'(1));
   endtask

   task automatic do_fetch(input logic [AW-1:0] a, output int g, output int r,
                           output logic [127:0] d, output logic [AW-1:0] a0,
                           output logic [AW-1:0] a1);
      bit ok1, ok2;
      ifu_addr = a; ifu_valid = 1;
      ok1 = 0; ok2 = 0; g = -1; r = -1; d = '0; a0 = '0; a1 = '0;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (ifu_ready) begin ok1 = 1; g = cyc; a0 = sram_addr; break; end
      end
      @(posedge CLK); #1;
      ifu_valid = 0;
      @(negedge CLK);
      a1 = sram_addr;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (ifu_rsp_valid) begin ok2 = 1; r = cyc; d = ifu_rdata; break; end
      end
      @(posedge CLK); #1;
      chk("ifu_grant_seen", 128'(ok1), 128'(1));
      chk("ifu_rsp_seen", 128'(ok2), 128'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int g, r, g2, n;
      logic [63:0] d;
      logic [127:0] fd;
      logic [AW-1:0] a0, a1;
      int gc[4];
      int gk[4];

      repeat (3) @(posedge CLK);
      #1 chk_on = 1;
      @(negedge CLK);
      chk("rst_ifu_ready", 128'(ifu_ready), '0);
      chk("rst_lsu_ready", 128'(lsu_ready), '0);
      chk("rst_sram_en", 128'(sram_en), '0);
      chk("rst_ifu_rsp_valid", 128'(ifu_rsp_valid), '0);
      chk("rst_lsu_rsp_valid", 128'(lsu_rsp_valid), '0);
      chk("rst_ifu_rdata", ifu_rdata, '0);
      chk("rst_lsu_rdata", 128'(lsu_rdata), '0);
      @(posedge CLK); #1 RST = 0;

      // write then read back
      do_lsu(1, 14'h10, 64'h1122334455667788, 8'hFF, g, r, d);
      chk("wr_latency", 128'(r - g), 128'(2));
      chk("wr_ack_data", 128'(d), '0);
      do_lsu(0, 14'h10, '0, '0, g, r, d);
      chk("rd_latency", 128'(r - g), 128'(2));
      chk("rd_data", 128'(d), 128'(64'h1122334455667788));

      // two-beat fetch from an odd address
      do_lsu(1, 14'h20, 64'hAAAA, 8'hFF, g, r, d);
      do_lsu(1, 14'h21, 64'hBBBB, 8'hFF, g, r, d);
      do_fetch(14'h21, g, r, fd, a0, a1);
      chk("fetch_addr0", 128'(a0), 128'(14'h20));
      chk("fetch_addr1", 128'(a1), 128'(14'h21));
      chk("fetch_latency", 128'(r - g), 128'(3));
      chk("fetch_data", fd, 128'h000000000000BBBB_000000000000AAAA);

      // byte strobes, including an all-zero strobe
      do_lsu(1, 14'h30, 64'hFFFFFFFFFFFFFFFF, 8'hFF, g, r, d);
      do_lsu(1, 14'h30, 64'h0, 8'h0F, g, r, d);
      do_lsu(0, 14'h30, '0, '0, g, r, d);
      chk("strobe_data", 128'(d), 128'(64'hFFFFFFFF00000000));
      do_lsu(1, 14'h30, 64'h5555555555555555, 8'h00, g, r, d);
      chk("zstrb_ack_latency", 128'(r - g), 128'(2));
      chk("zstrb_ack_data", 128'(d), '0);
      do_lsu(0, 14'h30, '0, '0, g, r, d);
      chk("zstrb_data", 128'(d), 128'(64'hFFFFFFFF00000000));

      // fetch of the last line in the address space
      do_lsu(1, 14'h3FFE, 64'h0123456789ABCDEF, 8'hFF, g, r, d);
      do_lsu(1, 14'h3FFF, 64'hFEDCBA9876543210, 8'hFF, g, r, d);
      do_fetch(14'h3FFF, g, r, fd, a0, a1);
      chk("top_addr0", 128'(a0), 128'(14'h3FFE));
      chk("top_addr1", 128'(a1), 128'(14'h3FFF));
      chk("top_data", fd, 128'hFEDCBA9876543210_0123456789ABCDEF);

      // response backpressure with a fetch waiting
      lsu_rsp_ready = 0;
      lsu_wen = 0; lsu_addr = 14'h10; lsu_valid = 1;
      g = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (lsu_ready) begin g = cyc; break; end
      end
      chk("bp_grant_seen", 128'(g >= 0), 128'(1));
      @(posedge CLK); #1;
      lsu_valid = 0; ifu_addr = 14'h20; ifu_valid = 1;
      @(negedge CLK);
      @(negedge CLK);
      for (int k = 0; k < 6; k++) begin
         chk("bp_rsp_valid", 128'(lsu_rsp_valid), 128'(1));
         chk("bp_rdata", 128'(lsu_rdata), 128'(64'h1122334455667788));
         chk("bp_ifu_ready", 128'(ifu_ready), '0);
         if (k < 5) @(negedge CLK);
      end
      @(posedge CLK); #1 lsu_rsp_ready = 1;
      @(negedge CLK);
      chk("bp_hs_valid", 128'(lsu_rsp_valid), 128'(1));
      @(negedge CLK);
      chk("bp_gap_valid", 128'(lsu_rsp_valid), '0);
      chk("bp_gap_ifu_ready", 128'(ifu_ready), '0);
      @(negedge CLK);
      chk("bp_ifu_grant", 128'(ifu_ready), 128'(1));
      @(posedge CLK); #1 ifu_valid = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (ifu_rsp_valid) break;
      end
      @(posedge CLK); #1;

      // reset while the second fetch beat is in flight
      do_lsu(1, 14'h40, 64'h4040404040404040, 8'hFF, g, r, d);
      do_lsu(1, 14'h41, 64'h4141414141414141, 8'hFF, g, r, d);
      ifu_addr = 14'h40; ifu_valid = 1;
      g = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (ifu_ready) begin g = cyc; break; end
      end
      chk("rstf_grant_seen", 128'(g >= 0), 128'(1));
      @(posedge CLK); #1 ifu_valid = 0; RST = 1;
      @(posedge CLK); #1 RST = 0;
      @(negedge CLK);
      chk("rstf_sram_en", 128'(sram_en), '0);
      chk("rstf_sram_addr", 128'(sram_addr), '0);
      chk("rstf_ifu_rsp_valid", 128'(ifu_rsp_valid), '0);
      chk("rstf_ifu_rdata", ifu_rdata, '0);
      chk("rstf_lsu_rdata", 128'(lsu_rdata), '0);
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         chk("rstf_no_rsp", 128'(ifu_rsp_valid), '0);
      end
      @(posedge CLK); #1;
      do_fetch(14'h41, g, r, fd, a0, a1);
      chk("rstf_fetch_latency", 128'(r - g), 128'(3));
      chk("rstf_fetch_data", fd, 128'h4141414141414141_4040404040404040);

      // continuous requests on both ports from reset
      RST = 1; ifu_addr = 14'h21; ifu_valid = 1; lsu_addr = 14'h10; lsu_wen = 0; lsu_valid = 1;
      @(posedge CLK); #1;
      @(posedge CLK); #1 RST = 0;
      g2 = cyc;
      n = 0;
      for (int k = 0; k < 4; k++) begin gc[k] = 0; gk[k] = 0; end
      for (int i = 0; i < 80 && n < 4; i++) begin
         @(negedge CLK);
         if (ifu_ready) begin gk[n] = 1; gc[n] = cyc; n++; end
         else if (lsu_ready) begin gk[n] = 2; gc[n] = cyc; n++; end
      end
      @(posedge CLK); #1 ifu_valid = 0; lsu_valid = 0;
      repeat (8) @(posedge CLK);
      #1;
      chk("rr_count", 128'(n), 128'(4));
      chk("rr_first_cycle", 128'(gc[0] - g2), '0);
      chk("rr_k0", 128'(gk[0]), 128'(1));
      chk("rr_k1", 128'(gk[1]), 128'(2));
      chk("rr_k2", 128'(gk[2]), 128'(1));
      chk("rr_k3", 128'(gk[3]), 128'(2));
      chk("rr_gap_if", 128'(gc[1] - gc[0]), 128'(5));
      chk("rr_gap_ls", 128'(gc[2] - gc[1]), 128'(4));
      chk("rr_gap_if2", 128'(gc[3] - gc[2]), 128'(5));

      chk_on = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
